nn_mlp_seq: RTL and testbench
=============================

Name: nn_mlp_seq

Overview:
- Time-multiplexed, parametrised successor of the fully combinational two-layer perceptron top.
- One shared MAC evaluates every hidden and output neuron sequentially, reading weights from an external synchronous weight memory.
- Sits between the feature-extraction front end (input stream) and the PLL decision logic (output stream).
- Trades area for latency; channel counts and widths are set by parameters.

Parameters:
- N_IN, 80, number of input features
- N_HID, 27, hidden neurons
- N_OUT, 10, output neurons
- IN_W, 6, input width (unsigned)
- ACT_W, 7, hidden activation width (signed)
- OUT_W, 8, output width (signed)
- W_W, 8, weight/bias width (signed)
- ACC_W, 24, accumulator width (signed)
- SHIFT1, 4, arithmetic right shift applied to the layer-1 accumulator
- SHIFT2, 4, arithmetic right shift applied to the layer-2 accumulator
- WA_W, 12, weight address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled in IDLE only
- busy  out  1  high in every state other than IDLE
- in_data  in  IN_W  input feature, unsigned
- in_valid  in  1  in_data valid
- in_ready  out  1  high only in LOAD
- w_addr  out  WA_W  weight memory read address
- w_data  in  W_W  weight read data, returned 1 cycle after w_addr
- out_data  out  OUT_W  output neuron value, signed
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_last  out  1  marks output neuron N_OUT-1

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all counters and the accumulator cleared. Input and hidden register files are not reset.
- FSM: IDLE -> LOAD -> L1 -> L2 -> EMIT -> IDLE.
  - IDLE -> LOAD: on start.
  - start while busy is ignored.
- LOAD: accepts one feature per in_valid&&in_ready beat into x[0..N_IN-1]. After N_IN beats, moves to L1.
- Weight map:
  - Layer-1 neuron j, input i: address j*(N_IN+1)+i; i=N_IN holds the bias.
  - Layer-2 neuron k, input j: address N_HID*(N_IN+1) + k*(N_HID+1) + j; j=N_HID holds the bias.
- MAC pipeline: w_addr is issued in cycle t and w_data is consumed in t+1.
  - Data path: acc += w*x, where x is zero-extended for layer 1 and signed for layer 2.
  - The bias entry adds w sign-extended, not multiplied.
  - Each neuron takes (fan-in+1) issue cycles plus 1 drain/writeback cycle. Layer 1 is N_HID*(N_IN+2) cycles; layer 2 is N_OUT*(N_HID+2) cycles.
- Layer-1 writeback: v = acc>>>SHIFT1, then ReLU, then saturate to [0, 2^(ACT_W-1)-1], stored as h[j]. The accumulator clears for the next neuron.
- Layer-2 writeback: v = acc>>>SHIFT2, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1], stored as y[k].
- The accumulator never wraps for the default parameters; overflow behaviour for other parameter sets is undefined.
- EMIT: presents y[0..N_OUT-1] in order.
  - out_valid stays high and out_data stays stable until out_ready; out_ready low stalls indefinitely.
  - out_last is asserted with y[N_OUT-1]. Its handshake returns the FSM to IDLE, and busy drops the next cycle.
- Latency, start to first out_valid at defaults, with in_valid held high: 1 + 80 + 2214 + 290 cycles.
- rst_n asserted in any state aborts the frame immediately. No partial output is emitted after release.

Optional Feature:
- Macro: NN_ARGMAX_EN.
- Defined:
  - Adds output class_idx, width $clog2(N_OUT), and output class_valid.
  - The index of the maximum y is tracked during layer-2 writeback; ties resolve to the lowest index.
  - class_valid pulses for one cycle with the out_last handshake.
  - Both outputs reset to 0.
- Undefined: the ports and tracking logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package nn_pkg holds:
  - the FSM state enum;
  - saturation/ReLU helper functions;
  - the weight-address base constant function, layer-2 base = N_HID*(N_IN+1).
- One sub-module, nn_mac_unit: multiply-accumulate, shift, and saturate/ReLU selected by a layer flag.
- Register files and the FSM stay in the top.

Test Plan:
- Bias-only layer 1 and 1-weight layer 2:
  - Stimulus: all x=0; L1 weights 0, bias 64; L2 weights 1, bias 0.
  - Required: every h=4 and every out=6 (108>>>4).
- Positive saturation:
  - Stimulus: x=63, all L1 weights 127; L2 weights 127, bias 0.
  - Required: h=63 and every out=127.
- Negative path:
  - Stimulus: L1 weights -128, giving h=0 by ReLU; L2 weights 0, bias -128.
  - Required: every out=-8.
- Output backpressure:
  - Stimulus: toggle out_ready randomly and hold it low for 50 cycles on y[3].
  - Required: no output lost or duplicated, out_data stable while stalled, out_last only on the 10th beat.
- Reset and ignored start:
  - Stimulus: rst_n low for 1 cycle midway through L1, then a full frame; also pulse start during L2.
  - Required: the start during L2 has no effect; after reset all outputs are 0 and the next frame matches the golden model.
- Latency and argmax (NN_ARGMAX_EN):
  - Stimulus: count cycles from start to first out_valid with in_valid held high; set y[2]=y[7]=max.
  - Required: 2585 cycles; class_idx=2.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared types and helpers for the sequential perceptron.
// FSM state enum, ReLU/saturation helpers and the layer-2 weight base.
package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_L1,
        S_L2,
        S_EMIT
    } state_t;

    // Clamp v to [0, 2^(w-1)-1].
    function automatic logic signed [31:0] relu_sat(
        input logic signed [31:0] v,
        input int                 w
    );
        logic signed [31:0] hi;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (v < 0) return '0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Clamp v to [-2^(w-1), 2^(w-1)-1].
    function automatic logic signed [31:0] sat_s(
        input logic signed [31:0] v,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // First layer-2 weight address; layer 1 occupies everything below.
    function automatic int l2_base(input int n_in, input int n_hid);
        return n_hid * (n_in + 1);
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// nn_mac_unit: shared multiply-accumulate with per-layer shift and clamp.
// Layer flag picks the operand extension; both writeback values are offered.
module nn_mac_unit
    import nn_pkg::*;
#(
    parameter int IN_W   = 6,
    parameter int ACT_W  = 7,
    parameter int OUT_W  = 8,
    parameter int W_W    = 8,
    parameter int ACC_W  = 24,
    parameter int SHIFT1 = 4,
    parameter int SHIFT2 = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic                    i_bias,
    input  logic                    i_wb,
    input  logic                    i_layer2,
    input  logic signed [W_W-1:0]   i_w,
    input  logic [IN_W-1:0]         i_xu,
    input  logic signed [ACT_W-1:0] i_xs,
    output logic signed [ACT_W-1:0] o_h,
    output logic signed [OUT_W-1:0] o_y
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_xe;
    logic signed [ACC_W-1:0] w_we;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_s1;
    logic signed [ACC_W-1:0] w_s2;

    // Operand extension, product/bias term, next sum and clamped results.
    always_comb begin
        w_xe   = i_layer2 ? ACC_W'(i_xs) : $signed(ACC_W'({1'b0, i_xu}));
        w_we   = ACC_W'(i_w);
        w_prod = w_we * w_xe;
        w_term = i_bias ? w_we : w_prod;
        w_sum  = r_acc + w_term;
        w_s1   = w_sum >>> SHIFT1;
        w_s2   = w_sum >>> SHIFT2;
        o_h    = ACT_W'(relu_sat(32'(w_s1), ACT_W));
        o_y    = OUT_W'(sat_s(32'(w_s2), OUT_W));
    end

    // Accumulator: restarts at every neuron writeback and outside MAC states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr || i_wb) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/nn_mlp_seq.sv
// nn_mlp_seq: time-multiplexed two-layer perceptron with one shared MAC.
// Define NN_ARGMAX_EN to add class_idx/class_valid argmax outputs.
module nn_mlp_seq
    import nn_pkg::*;
#(
    parameter int N_IN   = 80,
    parameter int N_HID  = 27,
    parameter int N_OUT  = 10,
    parameter int IN_W   = 6,
    parameter int ACT_W  = 7,
    parameter int OUT_W  = 8,
    parameter int W_W    = 8,
    parameter int ACC_W  = 24,
    parameter int SHIFT1 = 4,
    parameter int SHIFT2 = 4,
    parameter int WA_W   = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WA_W-1:0]         w_addr,
    input  logic [W_W-1:0]          w_data,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
`ifdef NN_ARGMAX_EN
    ,
    output logic [$clog2(N_OUT)-1:0] class_idx,
    output logic                     class_valid
`endif
);

    localparam int FMAX = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int CMAX = (FMAX + 2 > N_OUT) ? FMAX + 2 : N_OUT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int XIW  = $clog2(N_IN);
    localparam int HIW  = $clog2(N_HID);
    localparam int YIW  = $clog2(N_OUT);

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]   r_i;
    logic [CW-1:0]   r_n;
    logic [WA_W-1:0] r_waddr;

    logic [IN_W-1:0]         r_x [N_IN];
    logic signed [ACT_W-1:0] r_h [N_HID];
    logic signed [OUT_W-1:0] r_y [N_OUT];

    logic                    w_l1;
    logic                    w_l2;
    logic                    w_mac;
    logic [CW-1:0]           w_fan;
    logic                    w_issue;
    logic                    w_cons;
    logic                    w_wb;
    logic                    w_nlast;
    logic [CW-1:0]           w_xi;
    logic [IN_W-1:0]         w_xu;
    logic signed [ACT_W-1:0] w_xs;
    logic                    w_in_hs;
    logic                    w_olast;
    logic signed [ACT_W-1:0] w_h;
    logic signed [OUT_W-1:0] w_y;

    // Issue/consume/writeback strobes; counter c issues c and consumes c-1.
    always_comb begin
        w_l1    = (r_state == S_L1);
        w_l2    = (r_state == S_L2);
        w_mac   = w_l1 || w_l2;
        w_fan   = w_l2 ? CW'(N_HID) : CW'(N_IN);
        w_issue = w_mac && (r_i <= w_fan);
        w_cons  = w_mac && (r_i != '0);
        w_wb    = w_mac && (r_i == w_fan + 1'b1);
        w_nlast = w_l2 ? (r_n == CW'(N_OUT - 1))
                       : (r_n == CW'(N_HID - 1));
        w_xi    = r_i - 1'b1;
        w_xu    = (w_xi < CW'(N_IN)) ? r_x[XIW'(w_xi)] : '0;
        w_xs    = (w_xi < CW'(N_HID)) ? r_h[HIW'(w_xi)] : '0;
        w_in_hs = in_valid && (r_state == S_LOAD);
        w_olast = (r_state == S_EMIT) && (r_n == CW'(N_OUT - 1));
    end

    nn_mac_unit #(
        .IN_W   (IN_W),
        .ACT_W  (ACT_W),
        .OUT_W  (OUT_W),
        .W_W    (W_W),
        .ACC_W  (ACC_W),
        .SHIFT1 (SHIFT1),
        .SHIFT2 (SHIFT2)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (!w_mac),
        .i_en     (w_cons),
        .i_bias   (w_wb),
        .i_wb     (w_wb),
        .i_layer2 (w_l2),
        .i_w      (w_data),
        .i_xu     (w_xu),
        .i_xs     (w_xs),
        .o_h      (w_h),
        .o_y      (w_y)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        busy      = (r_state != S_IDLE);
        in_ready  = (r_state == S_LOAD);
        out_valid = (r_state == S_EMIT);
        out_last  = w_olast;
        out_data  = '0;
        w_addr    = r_waddr;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_LOAD;
            S_LOAD: if (in_valid && r_i == CW'(N_IN - 1)) w_next = S_L1;
            S_L1:   if (w_wb && w_nlast) w_next = S_L2;
            S_L2:   if (w_wb && w_nlast) w_next = S_EMIT;
            S_EMIT: begin
                out_data = r_y[YIW'(r_n)];
                if (out_ready && w_olast) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Input/neuron counters and the running weight address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i     <= '0;
            r_n     <= '0;
            r_waddr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_i     <= '0;
                    r_n     <= '0;
                    r_waddr <= '0;
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_i <= (r_i == CW'(N_IN - 1)) ? '0 : r_i + 1'b1;
                    end
                end
                S_L1, S_L2: begin
                    if (w_issue) r_waddr <= r_waddr + 1'b1;
                    if (w_wb) begin
                        r_i <= '0;
                        r_n <= w_nlast ? '0 : r_n + 1'b1;
                        if (w_l1 && w_nlast) begin
                            r_waddr <= WA_W'(l2_base(N_IN, N_HID));
                        end
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) r_n <= w_olast ? '0 : r_n + 1'b1;
                end
                default: begin
                    r_i <= '0;
                    r_n <= '0;
                end
            endcase
        end
    end

    // Feature, hidden and output register files (not reset).
    always_ff @(posedge clk) begin
        if (w_in_hs) r_x[XIW'(r_i)] <= in_data;
        if (w_wb && w_l1) r_h[HIW'(r_n)] <= w_h;
        if (w_wb && w_l2) r_y[YIW'(r_n)] <= w_y;
    end

`ifdef NN_ARGMAX_EN
    logic signed [OUT_W-1:0] r_max;
    logic [YIW-1:0]          r_idx;

    // Running maximum over layer-2 writebacks; strict > keeps lowest index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (w_wb && w_l2 && (r_n == '0 || w_y > r_max)) begin
            r_max <= w_y;
            r_idx <= YIW'(r_n);
        end
    end

    assign class_idx   = r_idx;
    assign class_valid = out_ready && w_olast;
`endif

endmodule

// File: tb/tb_nn_mlp_seq.sv
// tb_nn_mlp_seq: randomized self-checking bench for nn_mlp_seq.
// Behavioural golden model; NN_ARGMAX_EN adds argmax checks.
module tb_nn_mlp_seq;

    localparam int N_IN   = 80;
    localparam int N_HID  = 27;
    localparam int N_OUT  = 10;
    localparam int IN_W   = 6;
    localparam int ACT_W  = 7;
    localparam int OUT_W  = 8;
    localparam int W_W    = 8;
    localparam int ACC_W  = 24;
    localparam int SHIFT1 = 4;
    localparam int SHIFT2 = 4;
    localparam int WA_W   = 12;
    localparam int NW     = 1 << WA_W;
    localparam int L1C    = N_HID * (N_IN + 2);
    localparam int L2C    = N_OUT * (N_HID + 2);
    localparam int L2B    = N_HID * (N_IN + 1);
    localparam int AMAX   = (1 << (ACT_W - 1)) - 1;
    localparam int YMAX   = (1 << (OUT_W - 1)) - 1;
    localparam int YMIN   = -(1 << (OUT_W - 1));

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    busy;
    logic [IN_W-1:0]         in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [WA_W-1:0]         w_addr;
    logic [W_W-1:0]          w_data;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic                    out_last;
`ifdef NN_ARGMAX_EN
    logic [$clog2(N_OUT)-1:0] class_idx;
    logic                     class_valid;
`endif

    nn_mlp_seq #(
        .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .IN_W(IN_W),
        .ACT_W(ACT_W), .OUT_W(OUT_W), .W_W(W_W), .ACC_W(ACC_W),
        .SHIFT1(SHIFT1), .SHIFT2(SHIFT2), .WA_W(WA_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .w_addr(w_addr), .w_data(w_data),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
`ifdef NN_ARGMAX_EN
        , .class_idx(class_idx), .class_valid(class_valid)
`endif
    );

    always #5 clk = ~clk;

    int wm [NW];
    int xv [N_IN];
    int hm [N_HID];
    int ym [N_OUT];
    int am;
    int got [N_OUT];
    bit lastf [N_OUT];
    int cls_hits;
    int cls_beat;
    int cls_got;
    int n_pass = 0;
    int n_total = 0;

    // Synchronous weight memory: one cycle read latency.
    always @(posedge clk) w_data <= W_W'(wm[w_addr]);

    task automatic model();
        int s;
        int v;
        for (int j = 0; j < N_HID; j++) begin
            s = wm[j * (N_IN + 1) + N_IN];
            for (int i = 0; i < N_IN; i++) s += xv[i] * wm[j * (N_IN + 1) + i];
            v = s >>> SHIFT1;
            hm[j] = (v < 0) ? 0 : ((v > AMAX) ? AMAX : v);
        end
        am = 0;
        for (int k = 0; k < N_OUT; k++) begin
            s = wm[L2B + k * (N_HID + 1) + N_HID];
            for (int j = 0; j < N_HID; j++) s += hm[j] * wm[L2B + k * (N_HID + 1) + j];
            v = s >>> SHIFT2;
            ym[k] = (v < YMIN) ? YMIN : ((v > YMAX) ? YMAX : v);
            if (ym[k] > ym[am]) am = k;
        end
    endtask

    task automatic set_w(input int w1, input int b1, input int w2, input int b2);
        for (int j = 0; j < N_HID; j++)
            for (int i = 0; i <= N_IN; i++)
                wm[j * (N_IN + 1) + i] = (i == N_IN) ? b1 : w1;
        for (int k = 0; k < N_OUT; k++)
            for (int j = 0; j <= N_HID; j++)
                wm[L2B + k * (N_HID + 1) + j] = (j == N_HID) ? b2 : w2;
    endtask

    task automatic rand_wx();
        for (int a = 0; a < L2B; a++) wm[a] = $urandom_range(0, 16) - 8;
        for (int a = L2B; a < L2B + L2C - N_OUT; a++) wm[a] = $urandom_range(0, 255) - 128;
        for (int i = 0; i < N_IN; i++) xv[i] = $urandom_range(0, 63);
    endtask

    task automatic set_x(input int v);
        for (int i = 0; i < N_IN; i++) xv[i] = v;
    endtask

    // Drives one whole frame and captures the emitted beats.
    task automatic run_frame(input bit bp, input bit poke,
                             output int lat, output int viol,
                             output int extra, output bit tmo);
        int idx;
        int nb;
        int cyc;
        int stall;
        bit pend;
        logic signed [OUT_W-1:0] pd;
        idx = 0; nb = 0; cyc = 0; stall = 0; pend = 0; pd = '0;
        lat = 0; viol = 0; extra = 0; tmo = 0;
        cls_hits = 0; cls_beat = -1; cls_got = -1;
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b1;
        in_data = IN_W'(xv[0]);
        out_ready = 1'b0;
        while (nb < N_OUT && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = (poke && cyc == 1 + N_IN + L1C + 7);
            if (idx < N_IN) begin
                in_data = IN_W'(xv[idx]);
                if (in_ready) idx++;
            end
            if (bp && out_valid && nb == 3 && stall < 50) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            #1;
            if (out_valid && lat == 0) lat = cyc;
`ifdef NN_ARGMAX_EN
            if (class_valid) begin
                cls_hits++;
                cls_beat = nb;
                cls_got = int'(class_idx);
            end
`endif
            if (out_valid) begin
                if (pend && out_data !== pd) viol++;
                if (out_ready) begin
                    got[nb] = out_data;
                    lastf[nb] = out_last;
                    nb++;
                    pend = 0;
                end else begin
                    pend = 1;
                    pd = out_data;
                end
            end
        end
        tmo = (nb < N_OUT);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (out_valid) extra++;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ({busy, in_ready, out_valid, out_last} !== 4'b0)
            $display("FAIL reset_flags got %b exp 0000", {busy, in_ready, out_valid, out_last});
        else n_pass++;
        n_total++;
        if (out_data !== '0) $display("FAIL reset_out_data got %0d exp 0", out_data);
        else n_pass++;
        n_total++;
        if (w_addr !== '0) $display("FAIL reset_w_addr got %0d exp 0", w_addr);
        else n_pass++;
`ifdef NN_ARGMAX_EN
        n_total++;
        if ({class_idx, class_valid} !== '0)
            $display("FAIL reset_class got %0d/%0d exp 0/0", class_idx, class_valid);
        else n_pass++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_release_busy got %b exp 0", busy);
        else n_pass++;
    endtask

    task automatic test_bias_only();
        int lat, viol, extra, badl;
        bit tmo;
        set_x(0);
        set_w(0, 64, 1, 0);
        run_frame(0, 0, lat, viol, extra, tmo);
        n_total++;
        if (tmo) $display("FAIL bias_timeout got timeout exp %0d beats", N_OUT);
        else n_pass++;
        badl = 0;
        for (int k = 0; k < N_OUT; k++) begin
            n_total++;
            if (got[k] !== 6) $display("FAIL bias_out%0d got %0d exp 6", k, got[k]);
            else n_pass++;
            if (lastf[k] != (k == N_OUT - 1)) badl++;
        end
        n_total++;
        if (badl !== 0) $display("FAIL bias_last got %0d bad beats exp 0", badl);
        else n_pass++;
    endtask

    task automatic test_pos_sat();
        int lat, viol, extra;
        bit tmo;
        set_x(63);
        set_w(127, 127, 127, 0);
        run_frame(0, 0, lat, viol, extra, tmo);
        for (int k = 0; k < N_OUT; k++) begin
            n_total++;
            if (got[k] !== YMAX) $display("FAIL possat_out%0d got %0d exp %0d", k, got[k], YMAX);
            else n_pass++;
        end
    endtask

    task automatic test_neg_path();
        int lat, viol, extra;
        bit tmo;
        for (int i = 0; i < N_IN; i++) xv[i] = $urandom_range(0, 63);
        set_w(-128, -128, 0, -128);
        run_frame(0, 0, lat, viol, extra, tmo);
        for (int k = 0; k < N_OUT; k++) begin
            n_total++;
            if (got[k] !== -8) $display("FAIL neg_out%0d got %0d exp -8", k, got[k]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int lat, viol, extra, badl;
        bit tmo;
        rand_wx();
        model();
        run_frame(1, 0, lat, viol, extra, tmo);
        n_total++;
        if (tmo) $display("FAIL bp_timeout got timeout exp %0d beats", N_OUT);
        else n_pass++;
        badl = 0;
        for (int k = 0; k < N_OUT; k++) begin
            n_total++;
            if (got[k] !== ym[k]) $display("FAIL bp_out%0d got %0d exp %0d", k, got[k], ym[k]);
            else n_pass++;
            if (lastf[k] != (k == N_OUT - 1)) badl++;
        end
        n_total++;
        if (viol !== 0) $display("FAIL bp_stable got %0d changes exp 0", viol);
        else n_pass++;
        n_total++;
        if (extra !== 0) $display("FAIL bp_extra_beats got %0d exp 0", extra);
        else n_pass++;
        n_total++;
        if (badl !== 0) $display("FAIL bp_last got %0d bad beats exp 0", badl);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int lat, viol, extra, idx, cnt;
        bit tmo;
        rand_wx();
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b1;
        idx = 0;
        cnt = 0;
        while (idx < N_IN && cnt < 1000) begin
            @(negedge clk);
            cnt++;
            start = 1'b0;
            in_data = IN_W'(xv[idx]);
            if (in_ready) idx++;
        end
        in_valid = 1'b0;
        repeat (100) @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL abort_in_l1 got busy %b exp 1", busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, out_valid, out_last, out_data, w_addr} !== '0)
            $display("FAIL abort_outputs got busy %b addr %0d exp all 0", busy, w_addr);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ({busy, out_valid, in_ready} !== 3'b0)
            $display("FAIL abort_idle got %b exp 000", {busy, out_valid, in_ready});
        else n_pass++;
        rand_wx();
        model();
        run_frame(0, 1, lat, viol, extra, tmo);
        for (int k = 0; k < N_OUT; k++) begin
            n_total++;
            if (got[k] !== ym[k]) $display("FAIL abort_out%0d got %0d exp %0d", k, got[k], ym[k]);
            else n_pass++;
        end
        #1;
        n_total++;
        if (busy !== 1'b0 || extra !== 0)
            $display("FAIL ignored_start got busy %b extra %0d exp 0/0", busy, extra);
        else n_pass++;
    endtask

    task automatic test_latency_argmax();
        int lat, viol, extra;
        bit tmo;
        for (int i = 0; i < N_IN; i++) xv[i] = $urandom_range(0, 63);
        set_w(0, 64, 0, 0);
        for (int k = 0; k < N_OUT; k++)
            wm[L2B + k * (N_HID + 1) + N_HID] = (k == 2 || k == 7) ? 112 : k * 8 - 40;
        model();
        run_frame(0, 0, lat, viol, extra, tmo);
        n_total++;
        if (lat !== 1 + N_IN + L1C + L2C)
            $display("FAIL latency got %0d exp %0d", lat, 1 + N_IN + L1C + L2C);
        else n_pass++;
        for (int k = 0; k < N_OUT; k++) begin
            n_total++;
            if (got[k] !== ym[k]) $display("FAIL lat_out%0d got %0d exp %0d", k, got[k], ym[k]);
            else n_pass++;
        end
`ifdef NN_ARGMAX_EN
        n_total++;
        if (cls_hits !== 1 || cls_beat !== N_OUT - 1)
            $display("FAIL class_valid got %0d pulses at beat %0d exp 1 at %0d",
                     cls_hits, cls_beat, N_OUT - 1);
        else n_pass++;
        n_total++;
        if (cls_got !== am) $display("FAIL class_idx got %0d exp %0d", cls_got, am);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_bias_only();
        test_pos_sat();
        test_neg_path();
        test_backpressure();
        test_reset_abort();
        test_latency_argmax();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
